instr_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the multicycle datapath. It replaces the single IR load from

---
 rtl/instr_prefetch_queue_if.sv | 43 ++++
 rtl/instr_prefetch_queue.sv | 115 +++++++++++
 tb/tb_instr_prefetch_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue_if
//   Bundles the signals of the instruction prefetch queue: the memory read
//   port, the instruction head/pop port and the redirect port.
//   master : the prefetch queue side
//   slave  : the environment side (memory, controller, IR/TR)
// Signals
//   mem_req, mem_addr     read request and address (master -> slave)
//   mem_ready, mem_rdata  request accepted and read data (slave -> master)
//   instr_valid/word/pc   head entry of the queue (master -> slave)
//   instr_pop             consume head (slave -> master)
//   redirect, redirect_addr  flush and restart fetch (slave -> master)
//   occupancy             number of valid queue entries (master -> slave)
// ---------------------------------------------------------------------------
interface instr_prefetch_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_word;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_pop;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_word, instr_pc, occupancy,
        input  mem_ready, mem_rdata, instr_pop, redirect, redirect_addr
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_word, instr_pc, occupancy,
        output mem_ready, mem_rdata, instr_pop, redirect, redirect_addr
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue
//   Instruction-fetch front end: a DEPTH-entry circular prefetch queue fed by
//   a fetch PC that issues one memory read at a time. Each returned word is
//   stored together with its address. A redirect flushes the queue and
//   restarts fetching at redirect_addr; a read already in flight is completed
//   and its data thrown away.
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   instr_prefetch_queue_if.master (memory, head/pop, redirect, occupancy)
// ---------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 13,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_prefetch_queue_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] word_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic handshake;
    logic push;
    logic pop;

    always_comb begin
        handshake = mem_req_q && bus.mem_ready;
        // A redirect drops any push or pop that coincides with it.
        push = (state_q == REQ) && handshake && !bus.redirect;
        pop  = bus.instr_pop && (count_q != '0) && !bus.redirect;

        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fetch_pc_d = push ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
        state_d    = state_q;

        case (state_q)
            IDLE:    if (count_q != CNT_W'(DEPTH)) state_d = REQ;
            REQ:     if (count_d == CNT_W'(DEPTH)) state_d = IDLE;
            FLUSH:   if (handshake) state_d = REQ;
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = bus.redirect_addr;
            // A request still waiting for mem_ready must finish at its old
            // address, so it is parked in FLUSH until the memory accepts it.
            if (state_q == IDLE || handshake) begin
                state_d = REQ;
            end else begin
                state_d = FLUSH;
            end
        end

        mem_req_d  = (state_d != IDLE);
        // FLUSH keeps presenting the captured address; REQ always fetches at
        // the (next) fetch PC, which only moves on a completed handshake.
        mem_addr_d = (state_d == FLUSH) ? mem_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            if (push) begin
                word_q[wr_ptr_q] <= bus.mem_rdata;
                pc_q[wr_ptr_q]   <= fetch_pc_q;
            end
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_word  = word_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];
    assign bus.occupancy   = count_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_queue
//   Directed bench for instr_prefetch_queue. dut0 uses RESET_PC=0 and covers
//   fill, streaming, redirects and reset; dut1 uses RESET_PC=13'h1FFE to show
//   fetch-address wrap. Memory returns addr[7:0]+8'h10 as the data word.
// ---------------------------------------------------------------------------
module tb_instr_prefetch_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rdy0, pop0, redir0;
    logic [12:0] raddr0;
    logic        rdy1, pop1;

    instr_prefetch_queue_if #(.DATA_W(8), .ADDR_W(13), .DEPTH(4)) bus0 ();
    instr_prefetch_queue_if #(.DATA_W(8), .ADDR_W(13), .DEPTH(4)) bus1 ();

    assign bus0.mem_ready     = rdy0;
    assign bus0.mem_rdata     = bus0.mem_addr[7:0] + 8'h10;
    assign bus0.instr_pop     = pop0;
    assign bus0.redirect      = redir0;
    assign bus0.redirect_addr = raddr0;

    assign bus1.mem_ready     = rdy1;
    assign bus1.mem_rdata     = bus1.mem_addr[7:0] + 8'h10;
    assign bus1.instr_pop     = pop1;
    assign bus1.redirect      = 1'b0;
    assign bus1.redirect_addr = 13'h0;

    instr_prefetch_queue #(.DATA_W(8), .ADDR_W(13), .DEPTH(4), .RESET_PC(13'h0000)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    instr_prefetch_queue #(.DATA_W(8), .ADDR_W(13), .DEPTH(4), .RESET_PC(13'h1FFE)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;
    logic [20:0] sb0[$];
    logic [20:0] sb1[$];

    function automatic logic [20:0] ent(input logic [12:0] pc);
        logic [7:0] w;
        w = pc[7:0] + 8'h10;
        return {pc, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_sb0(input logic [12:0] start, input int n);
        for (int i = 0; i < n; i++) sb0.push_back(ent(start + 13'(i)));
    endtask

    // Wait (bounded) for a head entry, compare it with the scoreboard, pop it.
    task automatic drain0(input string tag, input int n);
        logic [20:0] exp;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!bus0.instr_valid && w < 30) begin
                tick();
                w++;
            end
            chk({tag, "_valid"}, 32'(bus0.instr_valid), 32'(1));
            if (bus0.instr_valid) begin
                exp = (sb0.size() != 0) ? sb0.pop_front() : '1;
                chk({tag, "_head"}, 32'({bus0.instr_pc, bus0.instr_word}), 32'(exp));
                pop0 = 1'b1;
                tick();
                pop0 = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required test completion");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1; pop0 = 1'b0; pop1 = 1'b0;
        redir0 = 1'b0; raddr0 = 13'h0;

        // Reset state
        tick(); tick();
        chk("rst_req",   32'(bus0.mem_req),     32'(0));
        chk("rst_valid", 32'(bus0.instr_valid), 32'(0));
        chk("rst_occ",   32'(bus0.occupancy),   32'(0));
        chk("rst_word",  32'(bus0.instr_word),  32'(0));
        chk("rst_pc",    32'(bus0.instr_pc),    32'(0));

        fill_sb0(13'h0000, 20);
        for (int i = 0; i < 4; i++) sb1.push_back(ent(13'h1FFE + 13'(i)));

        // T1 fill with zero-wait memory, no pop
        @(negedge clk) rst = 1'b1;
        tick();
        chk("t1_req1",   32'(bus0.mem_req),     32'(1));
        chk("t1_addr1",  32'(bus0.mem_addr),    32'(0));
        chk("t1_valid1", 32'(bus0.instr_valid), 32'(0));
        tick();
        chk("t1_valid2", 32'(bus0.instr_valid), 32'(1));
        chk("t1_occ2",   32'(bus0.occupancy),   32'(1));
        tick(); tick(); tick();
        chk("t1_occ4",   32'(bus0.occupancy),   32'(4));
        chk("t1_req_off", 32'(bus0.mem_req),    32'(0));
        tick(); tick();
        chk("t1_req_off2", 32'(bus0.mem_req),   32'(0));
        chk("t1_occ4b",  32'(bus0.occupancy),   32'(4));

        // T5 wrap on dut1: 1FFE, 1FFF, 0000, 0001
        chk("t5_occ", 32'(bus1.occupancy), 32'(4));
        for (int i = 0; i < 4; i++) begin
            chk("t5_head", 32'({bus1.instr_pc, bus1.instr_word}), 32'(sb1.pop_front()));
            pop1 = 1'b1;
            tick();
        end
        pop1 = 1'b0;

        // T2 stream: pop every cycle from a full queue
        for (int i = 0; i < 10; i++) begin
            chk("t2_valid", 32'(bus0.instr_valid), 32'(1));
            chk("t2_head", 32'({bus0.instr_pc, bus0.instr_word}), 32'(sb0.pop_front()));
            if (i >= 3) chk("t2_occ", 32'(bus0.occupancy), 32'(2));
            pop0 = 1'b1;
            tick();
        end
        pop0 = 1'b0;

        // T4 redirect plus pop on a full queue
        w = 0;
        while (bus0.occupancy != 3'd4 && w < 20) begin tick(); w++; end
        chk("t4_full", 32'(bus0.occupancy), 32'(4));
        redir0 = 1'b1; raddr0 = 13'h0200; pop0 = 1'b1;
        tick();
        redir0 = 1'b0; pop0 = 1'b0;
        chk("t4_occ0",   32'(bus0.occupancy),   32'(0));
        chk("t4_valid0", 32'(bus0.instr_valid), 32'(0));
        sb0.delete();
        fill_sb0(13'h0200, 8);
        chk("t4_req",  32'(bus0.mem_req),  32'(1));
        chk("t4_addr", 32'(bus0.mem_addr), 32'(13'h0200));
        drain0("t4", 3);

        // T3 redirect while a request waits for mem_ready
        w = 0;
        while (!(bus0.occupancy == 3'd4 && !bus0.mem_req) && w < 30) begin tick(); w++; end
        chk("t3_full", 32'(bus0.occupancy), 32'(4));
        rdy0 = 1'b0;
        drain0("t3pre", 1);
        w = 0;
        while (!bus0.mem_req && w < 10) begin tick(); w++; end
        chk("t3_req",   32'(bus0.mem_req),  32'(1));
        chk("t3_addr0", 32'(bus0.mem_addr), 32'(13'h0207));
        tick();
        chk("t3_addr1", 32'(bus0.mem_addr), 32'(13'h0207));
        redir0 = 1'b1; raddr0 = 13'h0100;
        tick();
        redir0 = 1'b0;
        chk("t3_addr2",  32'(bus0.mem_addr),    32'(13'h0207));
        chk("t3_req2",   32'(bus0.mem_req),     32'(1));
        chk("t3_occ2",   32'(bus0.occupancy),   32'(0));
        chk("t3_valid2", 32'(bus0.instr_valid), 32'(0));
        tick();
        chk("t3_addr3", 32'(bus0.mem_addr),  32'(13'h0207));
        chk("t3_occ3",  32'(bus0.occupancy), 32'(0));
        sb0.delete();
        fill_sb0(13'h0100, 6);
        rdy0 = 1'b1;
        tick();
        chk("t3_newaddr", 32'(bus0.mem_addr),    32'(13'h0100));
        chk("t3_valid4",  32'(bus0.instr_valid), 32'(0));
        drain0("t3", 2);

        // T6 asynchronous reset while in FLUSH
        rdy0 = 1'b0;
        w = 0;
        while (!bus0.mem_req && w < 10) begin tick(); w++; end
        redir0 = 1'b1; raddr0 = 13'h0400;
        tick();
        redir0 = 1'b0;
        chk("t6_flush_req", 32'(bus0.mem_req), 32'(1));
        #3 rst = 1'b0;
        #1;
        chk("t6_req0",   32'(bus0.mem_req),     32'(0));
        chk("t6_occ0",   32'(bus0.occupancy),   32'(0));
        chk("t6_valid0", 32'(bus0.instr_valid), 32'(0));
        #2 rst = 1'b1;
        rdy0 = 1'b1;
        sb0.delete();
        fill_sb0(13'h0000, 4);
        tick();
        chk("t6_req1",  32'(bus0.mem_req),  32'(1));
        chk("t6_addr1", 32'(bus0.mem_addr), 32'(0));
        drain0("t6", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
